// File: rtl/pixel_packer_pkg.sv
// Shared video helpers for the pixel packer slice.
// Counter sizing, slot mapping and the sync bundle.
package pixel_packer_pkg;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int cnt_width(input int pn);
    return (clog2(pn) < 1) ? 1 : clog2(pn);
  endfunction

  function automatic int slot_map(
    input int cnt,
    input int pn,
    input bit msb
  );
    return msb ? (pn - 1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/video_sync_delay.sv
// Fixed-depth shift register for video sync bundles.
// Keeps control signals aligned with pipelined data.
module video_sync_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/pixel_packer.sv
// Packs PACK_NUM active pixels into one wide word.
// Two-stage pipeline: holding register, then output.
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int DATA_W        = 24,
  parameter int PACK_NUM      = 2,
  parameter bit MSB_FIRST     = 1'b0,
  parameter bit FLUSH_PARTIAL = 1'b1
) (
  input  logic                         I_pixel_clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            I_pixel_data,
  input  logic                         I_hsync,
  input  logic                         I_vsync,
  input  logic                         I_de,
  output logic [DATA_W*PACK_NUM-1:0]   O_pixel_data,
  output logic                         O_valid,
  output logic [PACK_NUM-1:0]          O_keep,
  output logic                         O_sol,
  output logic                         O_eol,
  output logic                         O_hsync,
  output logic                         O_vsync,
  output logic                         O_de
);

  localparam int CW = cnt_width(PACK_NUM);
  localparam int W  = DATA_W * PACK_NUM;
  localparam logic [CW-1:0] LAST = CW'(PACK_NUM - 1);

  logic [CW-1:0]       cnt;
  logic [W-1:0]        acc_data;
  logic [PACK_NUM-1:0] acc_keep;
  logic [W-1:0]        merged_data;
  logic [PACK_NUM-1:0] merged_keep;
  logic [W-1:0]        hold_data;
  logic                hold_vld;
  logic                de_d;
  logic                vs_d;
  logic                sol_pend;

  logic                vs_rise;
  logic                last;
  logic                adv;
  logic                grp_done;
  logic                flush;

  logic                nx_valid;
  logic [W-1:0]        nx_data;
  logic [PACK_NUM-1:0] nx_keep;
  logic                nx_sol;
  logic                nx_eol;

  sync_t               sync_in;
  sync_t               sync_out;

  always_comb begin
    merged_data = acc_data;
    merged_keep = acc_keep;
    for (int s = 0; s < PACK_NUM; s++) begin
      if (s == slot_map(int'(cnt), PACK_NUM, MSB_FIRST)) begin
        merged_data[s*DATA_W +: DATA_W] = I_pixel_data;
        merged_keep[s] = 1'b1;
      end
    end
  end

  // A vsync rising edge aborts the group in progress.
  assign vs_rise  = I_vsync & ~vs_d;
  assign last     = (cnt == LAST);
  assign adv      = I_de & ~vs_rise & ~last;
  assign grp_done = I_de & ~vs_rise & last;
  assign flush    = ~I_de & ~vs_rise & (cnt != '0)
                  & FLUSH_PARTIAL;

  always_ff @(posedge I_pixel_clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
    end else if (adv) begin
      cnt      <= cnt + 1'b1;
      acc_data <= merged_data;
      acc_keep <= merged_keep;
    end else begin
      cnt      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
    end
  end

  always_ff @(posedge I_pixel_clk or posedge rst) begin
    if (rst) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
      de_d      <= 1'b0;
      vs_d      <= 1'b0;
      sol_pend  <= 1'b0;
    end else begin
      hold_vld  <= grp_done;
      hold_data <= grp_done ? merged_data : '0;
      de_d      <= I_de;
      vs_d      <= I_vsync;
      if (I_de & ~de_d)
        sol_pend <= 1'b1;
      else if (hold_vld | flush)
        sol_pend <= 1'b0;
    end
  end

  // hold_vld and flush never coincide: cnt is 0 after a full group.
  always_comb begin
    nx_valid = 1'b0;
    nx_data  = '0;
    nx_keep  = '0;
    nx_sol   = 1'b0;
    nx_eol   = 1'b0;
    unique case (1'b1)
      hold_vld: begin
        nx_valid = 1'b1;
        nx_data  = hold_data;
        nx_keep  = '1;
        nx_sol   = sol_pend;
        nx_eol   = ~I_de;
      end
      flush: begin
        nx_valid = 1'b1;
        nx_data  = acc_data;
        nx_keep  = acc_keep;
        nx_sol   = sol_pend;
        nx_eol   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_pixel_clk or posedge rst) begin
    if (rst) begin
      O_valid      <= 1'b0;
      O_pixel_data <= '0;
      O_keep       <= '0;
      O_sol        <= 1'b0;
      O_eol        <= 1'b0;
    end else begin
      O_valid      <= nx_valid;
      O_pixel_data <= nx_data;
      O_keep       <= nx_keep;
      O_sol        <= nx_sol;
      O_eol        <= nx_eol;
    end
  end

  assign sync_in = '{hsync: I_hsync, vsync: I_vsync, de: I_de};

  video_sync_delay #(
    .DEPTH(2),
    .WIDTH(3)
  ) u_sync (
    .clk  (I_pixel_clk),
    .rst  (rst),
    .din  (sync_in),
    .dout (sync_out)
  );

  assign O_hsync = sync_out.hsync;
  assign O_vsync = sync_out.vsync;
  assign O_de    = sync_out.de;

endmodule

// File: tb/tb_pixel_packer.sv
// Bench for pixel_packer: five configurations share one stimulus.
// A line-level model predicts every output word and sync delay.
module tb_pixel_packer;

  localparam int N  = 1200;
  localparam int NI = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs, vs, de;
  logic [23:0] px;

  always #5 clk = ~clk;

  logic [47:0] a_d; logic [1:0] a_k;
  logic a_v, a_s, a_e, a_hs, a_vs, a_de;
  logic [95:0] b_d; logic [3:0] b_k;
  logic b_v, b_s, b_e, b_hs, b_vs, b_de;
  logic [95:0] c_d; logic [3:0] c_k;
  logic c_v, c_s, c_e, c_hs, c_vs, c_de;
  logic [47:0] d_d; logic [1:0] d_k;
  logic d_v, d_s, d_e, d_hs, d_vs, d_de;
  logic [23:0] e_d; logic [0:0] e_k;
  logic e_v, e_s, e_e, e_hs, e_vs, e_de;

  pixel_packer #(.DATA_W(24), .PACK_NUM(2),
    .MSB_FIRST(1'b0), .FLUSH_PARTIAL(1'b1)) u_a (
    .I_pixel_clk(clk), .rst(rst), .I_pixel_data(px),
    .I_hsync(hs), .I_vsync(vs), .I_de(de),
    .O_pixel_data(a_d), .O_valid(a_v), .O_keep(a_k),
    .O_sol(a_s), .O_eol(a_e), .O_hsync(a_hs),
    .O_vsync(a_vs), .O_de(a_de));

  pixel_packer #(.DATA_W(24), .PACK_NUM(4),
    .MSB_FIRST(1'b0), .FLUSH_PARTIAL(1'b1)) u_b (
    .I_pixel_clk(clk), .rst(rst), .I_pixel_data(px),
    .I_hsync(hs), .I_vsync(vs), .I_de(de),
    .O_pixel_data(b_d), .O_valid(b_v), .O_keep(b_k),
    .O_sol(b_s), .O_eol(b_e), .O_hsync(b_hs),
    .O_vsync(b_vs), .O_de(b_de));

  pixel_packer #(.DATA_W(24), .PACK_NUM(4),
    .MSB_FIRST(1'b0), .FLUSH_PARTIAL(1'b0)) u_c (
    .I_pixel_clk(clk), .rst(rst), .I_pixel_data(px),
    .I_hsync(hs), .I_vsync(vs), .I_de(de),
    .O_pixel_data(c_d), .O_valid(c_v), .O_keep(c_k),
    .O_sol(c_s), .O_eol(c_e), .O_hsync(c_hs),
    .O_vsync(c_vs), .O_de(c_de));

  pixel_packer #(.DATA_W(24), .PACK_NUM(2),
    .MSB_FIRST(1'b1), .FLUSH_PARTIAL(1'b1)) u_d (
    .I_pixel_clk(clk), .rst(rst), .I_pixel_data(px),
    .I_hsync(hs), .I_vsync(vs), .I_de(de),
    .O_pixel_data(d_d), .O_valid(d_v), .O_keep(d_k),
    .O_sol(d_s), .O_eol(d_e), .O_hsync(d_hs),
    .O_vsync(d_vs), .O_de(d_de));

  pixel_packer #(.DATA_W(24), .PACK_NUM(1),
    .MSB_FIRST(1'b0), .FLUSH_PARTIAL(1'b1)) u_e (
    .I_pixel_clk(clk), .rst(rst), .I_pixel_data(px),
    .I_hsync(hs), .I_vsync(vs), .I_de(de),
    .O_pixel_data(e_d), .O_valid(e_v), .O_keep(e_k),
    .O_sol(e_s), .O_eol(e_e), .O_hsync(e_hs),
    .O_vsync(e_vs), .O_de(e_de));

  bit          st_rst [N];
  bit          st_de  [N];
  bit          st_hs  [N];
  bit          st_vs  [N];
  logic [23:0] st_px  [N];

  logic [95:0] x_data [NI][N];
  logic [3:0]  x_keep [NI][N];
  bit          x_v    [NI][N];
  bit          x_s    [NI][N];
  bit          x_e    [NI][N];
  bit          x_hs   [N];
  bit          x_vs   [N];
  bit          x_de   [N];

  logic [105:0] rec [NI][N];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int pn_of(input int i);
    case (i)
      0: return 2;
      1: return 4;
      2: return 4;
      3: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit msb_of(input int i);
    return i == 3;
  endfunction

  function automatic bit fl_of(input int i);
    return i != 2;
  endfunction

  function automatic void emit(input int i, input int k,
    input logic [23:0] q[$], input bit sol, input bit eol);
    logic [95:0] d;
    logic [3:0]  kp;
    int p;
    d  = '0;
    kp = '0;
    for (int j = 0; j < q.size(); j++) begin
      p = msb_of(i) ? (pn_of(i) - 1 - j) : j;
      d[p*24 +: 24] = q[j];
      kp[p] = 1'b1;
    end
    x_v[i][k]    = 1'b1;
    x_data[i][k] = d;
    x_keep[i][k] = kp;
    x_s[i][k]    = sol;
    x_e[i][k]    = eol;
  endfunction

  task automatic build(input int i);
    logic [23:0] q[$];
    bit pend, dp, vp;
    pend = 0; dp = 0; vp = 0;
    for (int k = 0; k < N; k++) begin
      x_v[i][k] = 0; x_data[i][k] = '0; x_keep[i][k] = '0;
      x_s[i][k] = 0; x_e[i][k] = 0;
    end
    for (int k = 0; k < N; k++) begin
      if (st_rst[k]) begin
        q.delete();
        pend = 0; dp = 0; vp = 0;
        x_v[i][k] = 0; x_data[i][k] = '0; x_keep[i][k] = '0;
        x_s[i][k] = 0; x_e[i][k] = 0;
        continue;
      end
      if (st_de[k] && !dp) pend = 1;
      if (st_vs[k] && !vp) begin
        q.delete();
      end else if (st_de[k]) begin
        q.push_back(st_px[k]);
        if (q.size() == pn_of(i)) begin
          if (k + 1 < N) emit(i, k + 1, q, pend, !st_de[k+1]);
          pend = 0;
          q.delete();
        end
      end else if (q.size() != 0) begin
        if (fl_of(i)) begin
          emit(i, k, q, pend, 1'b1);
          pend = 0;
        end
        q.delete();
      end
      dp = st_de[k];
      vp = st_vs[k];
    end
  endtask

  function automatic logic [105:0] dut_vec(input int i);
    case (i)
      0: return {a_hs, a_vs, a_de, a_v, a_s, a_e,
                 4'(a_k), 96'(a_d)};
      1: return {b_hs, b_vs, b_de, b_v, b_s, b_e,
                 4'(b_k), 96'(b_d)};
      2: return {c_hs, c_vs, c_de, c_v, c_s, c_e,
                 4'(c_k), 96'(c_d)};
      3: return {d_hs, d_vs, d_de, d_v, d_s, d_e,
                 4'(d_k), 96'(d_d)};
      default: return {e_hs, e_vs, e_de, e_v, e_s, e_e,
                 4'(e_k), 96'(e_d)};
    endcase
  endfunction

  task automatic check(input string name, input int k,
    input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               name, k, got, exp);
    end
  endtask

  function automatic logic [127:0] word(input int i,
    input int k);
    return 128'(rec[i][k][102:0]);
  endfunction

  function automatic logic [127:0] lit(input bit v,
    input bit s, input bit e, input logic [3:0] kp,
    input logic [95:0] d);
    return 128'({v, s, e, kp, d});
  endfunction

  initial begin
    int k;
    int g;
    int len;
    bit vsr;
    bit prev_de [NI];
    logic [105:0] got;
    logic [105:0] exp;

    for (int j = 0; j < N; j++) st_px[j] = '0;
    for (int j = 0; j < 3; j++) st_rst[j] = 1;
    st_de[5] = 1;  st_px[5]  = 24'h111111;
    st_de[6] = 1;  st_px[6]  = 24'h222222;
    st_de[10] = 1; st_px[10] = 24'hAAAAAA;
    st_de[11] = 1; st_px[11] = 24'hBBBBBB;
    for (int j = 0; j < 5; j++) begin
      st_de[15+j] = 1;
      st_px[15+j] = 24'(j + 1);
    end
    for (int j = 0; j < 3; j++) begin
      st_de[25+j] = 1;
      st_px[25+j] = 24'h31 + 24'(j);
    end
    st_rst[28] = 1; st_rst[29] = 1;
    for (int j = 0; j < 4; j++) begin
      st_de[32+j] = 1;
      st_px[32+j] = 24'h41 + 24'(j);
    end
    st_de[38] = 1; st_px[38] = 24'h77;

    k = 42;
    while (k < N - 8) begin
      g   = $urandom_range(1, 4);
      len = $urandom_range(1, 11);
      vsr = ($urandom_range(0, 5) == 0);
      for (int j = 0; j < g && k < N - 8; j++) begin
        st_hs[k] = (j == 0);
        st_vs[k] = vsr && (j == 0);
        k++;
      end
      for (int j = 0; j < len && k < N - 8; j++) begin
        st_de[k] = 1;
        st_px[k] = 24'($urandom);
        k++;
      end
    end

    for (int i = 0; i < NI; i++) build(i);
    for (int j = 0; j < N; j++) begin
      bit ok;
      ok = (j > 0) && !st_rst[j] && !st_rst[j-1];
      x_hs[j] = ok ? st_hs[j-1] : 1'b0;
      x_vs[j] = ok ? st_vs[j-1] : 1'b0;
      x_de[j] = ok ? st_de[j-1] : 1'b0;
    end

    rst = 1; de = 0; hs = 0; vs = 0; px = '0;
    for (int i = 0; i < NI; i++) prev_de[i] = 0;

    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      rst = st_rst[j];
      de  = st_de[j];
      hs  = st_hs[j];
      vs  = st_vs[j];
      px  = st_px[j];
      #1;
      if (j == 28)
        check("async_rst_clear", j,
              128'({a_v, a_s, a_e, a_k, a_d}), '0);
      check("no_full_flush_overlap", j,
            128'(u_b.hold_vld & u_b.flush), '0);
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        got = dut_vec(i);
        exp = {x_hs[j], x_vs[j], x_de[j], x_v[i][j],
               x_s[i][j], x_e[i][j], x_keep[i][j],
               x_data[i][j]};
        rec[i][j] = got;
        check($sformatf("cycle_inst%0d", i), j,
              128'(got), 128'(exp));
        if (got[102])
          check($sformatf("valid_in_de_inst%0d", i), j,
                128'(got[103] | prev_de[i]), 128'(1));
        prev_de[i] = got[103];
      end
    end

    check("pn2_line", 7, word(0, 7),
          lit(1, 1, 1, 4'h3, 96'h222222111111));
    check("msb_first", 12, word(3, 12),
          lit(1, 1, 1, 4'h3, 96'hAAAAAABBBBBB));
    check("pn4_full", 19, word(1, 19),
          lit(1, 1, 0, 4'hF, 96'h000004000003000002000001));
    check("pn4_flush", 20, word(1, 20),
          lit(1, 0, 1, 4'h1, 96'h5));
    check("nofl_full", 19, word(2, 19),
          lit(1, 1, 0, 4'hF, 96'h000004000003000002000001));
    check("nofl_drop", 20, word(2, 20), '0);
    check("pre_rst_word", 27, word(0, 27),
          lit(1, 1, 0, 4'h3, 96'h000032000031));
    check("in_rst_zero", 28, word(1, 28), '0);
    check("post_rst_line", 36, word(1, 36),
          lit(1, 1, 1, 4'hF, 96'h000044000043000042000041));
    check("pn4_one_pix", 39, word(1, 39),
          lit(1, 1, 1, 4'h1, 96'h77));
    check("pn1_one_pix", 39, word(4, 39),
          lit(1, 1, 1, 4'h1, 96'h77));
    check("de_delay", 7, 128'(rec[0][7][103]), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
- Parametrised single-clock pixel packer. Groups PACK_NUM consecutive active pixels of DATA_W bits into one wide word, qualified by a valid strobe.
- Successor to the fixed two-pixel 24-to-48 converter. Adds configurable pack ratio, slot ordering, partial-word flush with a keep mask, line start/end markers, and sync signals aligned to the data latency.
- Sits between the video timing/ISP front end and wide-datapath consumers (DDR writer, wide FIFO).

Parameters:
- DATA_W, 24, bits per input pixel (>=1)
- PACK_NUM, 2, pixels per output word (>=1)
- MSB_FIRST, 0, 0: first pixel of a group in slot 0 (LSBs); 1: first pixel in the top slot
- FLUSH_PARTIAL, 1, 1: emit an incomplete last group of a line, zero-padded; 0: discard it

Ports:
- I_pixel_clk  in  1  pixel clock; all logic on its rising edge
- rst  in  1  reset, asynchronous, active-high
- I_pixel_data  in  DATA_W  input pixel, sampled when I_de=1
- I_hsync  in  1  input horizontal sync
- I_vsync  in  1  input vertical sync
- I_de  in  1  input data enable
- O_pixel_data  out  DATA_W*PACK_NUM  packed word; slot k = bits [k*DATA_W +: DATA_W]
- O_valid  out  1  O_pixel_data/O_keep valid this cycle
- O_keep  out  PACK_NUM  per-slot mask of slots holding real pixels
- O_sol  out  1  first word of a line (qualified by O_valid)
- O_eol  out  1  last word of a line (qualified by O_valid)
- O_hsync  out  1  I_hsync delayed 2 cycles
- O_vsync  out  1  I_vsync delayed 2 cycles
- O_de  out  1  I_de delayed 2 cycles

Behaviour:
- Reset: clock and reset are decided as I_pixel_clk plus asynchronous active-high rst. While rst=1, all outputs are 0, the slot counter is 0, the holding register is empty, and the delay lines are cleared.
- Slot counter cnt runs 0..PACK_NUM-1. Each cycle with I_de=1:
  - The pixel is written to logical slot cnt. Physical slot = cnt if MSB_FIRST=0, else PACK_NUM-1-cnt.
  - cnt increments. At PACK_NUM-1 it wraps to 0 and the group is complete.
- Stage 1: a completed group, including the pixel sampled in the same cycle, loads the holding register on the next edge with keep = all ones.
- Stage 2: the holding content is emitted on the following edge.
  - O_eol = !I_de as sampled in the cycle the holding register is valid.
  - Fixed latency: the last pixel of a group sampled at edge t gives O_valid=1 at t+2.
- Partial group: I_de=0 with cnt!=0 marks a line end.
  - FLUSH_PARTIAL=1: on the next edge, emit the filled slots, unfilled slots as zero, O_keep showing only the filled physical slots, O_eol=1. Timing is again t+2 from the last pixel. cnt returns to 0.
  - FLUSH_PARTIAL=0: discard the partial group, clear cnt, emit nothing. That line then carries no O_eol unless its last group was full.
- Simultaneous events: a full-group emission and a partial flush cannot coincide, because cnt=0 after a completed group. The bench must assert this.
- O_sol is 1 on the first O_valid word after each I_de rising edge, then 0 until the next line.
- PACK_NUM=1: every pixel is emitted with 2-cycle latency, keep=1, and sol/eol both set on a 1-pixel line.
- When O_valid=0: O_pixel_data=0, O_keep=0, O_sol=0, O_eol=0.
- Rising edge of I_vsync: clears cnt and any partial group without output (frame abort). A word already in the holding register is still emitted.
- Reset asserted mid-line: all state drops immediately. After release, packing restarts at slot 0 on the next I_de=1.
- O_hsync/O_vsync/O_de are pure 2-stage delays, so they stay aligned with O_valid.

Decomposition:
- Shared video header/package holds:
  - a clog2 function for the cnt width (max(1, clog2(PACK_NUM)));
  - the slot-index mapping function (cnt, MSB_FIRST) -> physical slot.
- Sub-module video_sync_delay: parametrised depth/width shift register carrying {hsync, vsync, de}. Instanced here with DEPTH=2, WIDTH=3 and reusable elsewhere.

Test Plan:
- DATA_W=24, PACK_NUM=2, MSB_FIRST=0; line 0x111111, 0x222222 -> 2 cycles after the second pixel: O_pixel_data=0x222222111111, O_keep=2'b11, O_sol=1, O_eol=1.
- PACK_NUM=4, FLUSH_PARTIAL=1; 5-pixel line 1..5 (24-bit) -> word 1: slots 1,2,3,4, keep=4'hF, sol=1, eol=0. Next cycle: slot0=5, rest 0, keep=4'b0001, eol=1.
- Same 5-pixel line with FLUSH_PARTIAL=0 -> only one word (keep=4'hF, eol=0); no second O_valid.
- MSB_FIRST=1, PACK_NUM=2, pixels 0xAAAAAA then 0xBBBBBB -> O_pixel_data=0xAAAAAABBBBBB.
- Assert rst after 3 pixels of a PACK_NUM=4 line -> outputs 0 immediately. After release, a fresh 4-pixel line emits exactly one word with sol=1, eol=1, slot0 = first post-reset pixel.
- Random hsync/vsync/de pattern -> O_hsync/O_vsync/O_de equal the inputs delayed exactly 2 cycles. Every O_valid falls inside an O_de-high span or on its final edge+1 (partial flush).
